// File: rtl/lshift_pkg.sv
// lshift_pkg: shared types and default widths for the lshift_sched slice.
// Holds the scheduler state enum and the default data/count widths.
package lshift_pkg;

    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lshift_rr_arb.sv
// lshift_rr_arb: picks one of NREQ requesters, one-hot grant plus index.
// Ports: clk, rst (async, high), req (request bits), upd (grant taken,
//   advance pointer), grant (one-hot or zero), idx (encoded grant).
// LSHIFT_SCHED_RR_EN defined: round-robin from ptr; else lowest index wins.
module lshift_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    upd,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;

`ifdef LSHIFT_SCHED_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end
`else
    logic unused_seq;
    assign ptr        = '0;
    assign unused_seq = &{1'b0, clk, rst, upd};
`endif

    // Winner is the requester with the smallest distance (i - ptr) mod NREQ.
    always_comb begin
        int d;
        int best;
        grant = '0;
        idx   = '0;
        best  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NREQ;
            if (req[i] && d < best) begin
                best = d;
                idx  = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = (best < NREQ) && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/lshift_sched.sv
// lshift_sched: shares one W-bit rotate-left register among NREQ requesters.
// Ports: clk, rst (async, high); req_valid/req_ready/req_data/req_cnt per
//   requester; rsp_valid/rsp_ready/rsp_data/rsp_id response; busy.
// LSHIFT_SCHED_RR_EN selects round-robin (else fixed-priority) arbitration.
module lshift_sched
    import lshift_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_data,
    input  logic [NREQ*CNT_W-1:0]   req_cnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    state_t           state;
    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    gidx;
    logic             take;
    logic [W-1:0]     sel_data;
    logic [CNT_W-1:0] sel_cnt;

    assign take = (state == IDLE) && (|req_valid);

    lshift_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .upd   (take),
        .grant (grant),
        .idx   (gidx)
    );

    // Ready is held low while reset is asserted so it matches reset values.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign rsp_data  = data_q;

    always_comb begin
        sel_data = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*W +: W];
                sel_cnt  = req_cnt[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        data_q <= sel_data;
                        cnt_q  <= sel_cnt;
                        rsp_id <= gidx;
                        busy   <= 1'b1;
                        if (sel_cnt == '0) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    data_q <= {data_q[W-2:0], data_q[W-1]};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lshift_sched.sv
// tb_lshift_sched: self-checking bench for lshift_sched (table, random, corners).
// Works with and without LSHIFT_SCHED_RR_EN defined.
module tb_lshift_sched;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int CNT_W = 3;
    localparam int IW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_data;
    logic [NREQ*CNT_W-1:0] req_cnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_data;
    logic [IW-1:0]         rsp_id;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    lshift_sched #(
        .NREQ  (NREQ),
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_cnt   (req_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cnt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] d, input int c);
        int v;
        v = (int'(d) << c) | (int'(d) >> (W - c));
        return v[7:0];
    endfunction

    function automatic int arb_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void arb_commit(input int g);
`ifdef LSHIFT_SCHED_RR_EN
        mptr = (g + 1) % NREQ;
`else
        mptr = 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] d, input int c);
        req_data[id*W +: W]         = d;
        req_cnt[id*CNT_W +: CNT_W]  = c[CNT_W-1:0];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
        mptr = 0;
    endtask

    // Entered just before the handshake edge with the request presented.
    task automatic serve(input int g, input logic [7:0] expd, input int c,
                         input logic [NREQ-1:0] nxt, input int stall,
                         input string n);
        int         lat;
        logic [7:0] hd;
        logic [1:0] hid;
        tick();
        req_valid = nxt;
        #1;
        lat = 1;
        while (!rsp_valid && lat <= 40) begin
            chk({n, " busy"}, 32'(busy), 1);
            chk({n, " rdy_rot"}, 32'(req_ready), 0);
            tick();
            lat++;
        end
        chk({n, " latency"}, lat, c + 1);
        chk({n, " data"}, 32'(rsp_data), 32'(expd));
        chk({n, " id"}, 32'(rsp_id), g);
        chk({n, " busy_done"}, 32'(busy), 1);
        chk({n, " rdy_done"}, 32'(req_ready), 0);
        hd  = rsp_data;
        hid = rsp_id;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({n, " hold_valid"}, 32'(rsp_valid), 1);
            chk({n, " hold_data"}, 32'(rsp_data), 32'(hd));
            chk({n, " hold_id"}, 32'(rsp_id), 32'(hid));
            chk({n, " hold_rdy"}, 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk({n, " post_valid"}, 32'(rsp_valid), 0);
        chk({n, " post_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int               g;
        int               c;
        logic [7:0]       d;
        logic [NREQ-1:0]  m;
        int               exp_seq[4];

        vecs[0] = '{0, 8'h81, 1, 8'h03};
        vecs[1] = '{1, 8'hA5, 0, 8'hA5};
        vecs[2] = '{3, 8'h01, 7, 8'h80};
        vecs[3] = '{2, 8'hF0, 4, 8'h0F};
        vecs[4] = '{0, 8'h3C, 3, 8'hE1};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_cnt   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst rsp_data", 32'(rsp_data), 0);
        chk("rst rsp_id", 32'(rsp_id), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst busy", 32'(busy), 0);
        rst  = 1'b0;
        mptr = 0;
        tick();

        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].id, vecs[i].data, vecs[i].cnt);
            req_valid = NREQ'(1 << vecs[i].id);
            #1;
            chk("vec grant", 32'(req_ready), 32'(1 << vecs[i].id));
            arb_commit(vecs[i].id);
            serve(vecs[i].id, vecs[i].exp, vecs[i].cnt, '0, 0, "vec");
        end

        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                set_req(r, 8'($urandom), $urandom_range(0, 7));
            end
            m = NREQ'($urandom_range(0, 15));
            req_valid = m;
            #1;
            g = arb_pick(m);
            if (g < 0) begin
                chk("rnd idle_rdy", 32'(req_ready), 0);
                req_valid = '0;
                tick();
            end else begin
                chk("rnd grant", 32'(req_ready), 32'(1 << g));
                arb_commit(g);
                d = req_data[g*W +: W];
                c = int'(req_cnt[g*CNT_W +: CNT_W]);
                serve(g, rotl(d, c), c, '0, $urandom_range(0, 2), "rnd");
            end
        end

        set_req(3, 8'h5A, 2);
        req_valid = 4'b1000;
        #1;
        chk("stall grant", 32'(req_ready), 32'h8);
        arb_commit(3);
        serve(3, rotl(8'h5A, 2), 2, 4'b0010, 3, "stall");
        chk("stall next_grant", 32'(req_ready), 32'h2);
        req_valid = '0;
        tick();
        chk("drop busy", 32'(busy), 0);
        chk("drop rsp_valid", 32'(rsp_valid), 0);

        do_reset();
`ifdef LSHIFT_SCHED_RR_EN
        exp_seq = '{0, 2, 0, 2};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        set_req(0, 8'h11, 2);
        set_req(2, 8'h22, 2);
        req_valid = 4'b0101;
        #1;
        for (int n = 0; n < 4; n++) begin
            chk("rr grant", 32'(req_ready), 32'(1 << exp_seq[n]));
            arb_commit(exp_seq[n]);
            d = req_data[exp_seq[n]*W +: W];
            serve(exp_seq[n], rotl(d, 2), 2, 4'b0101, 0, "rr");
        end
        req_valid = '0;
        tick();

        set_req(2, 8'h77, 7);
        req_valid = 4'b0100;
        #1;
        chk("mid grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("mid rsp_valid", 32'(rsp_valid), 0);
        chk("mid rsp_data", 32'(rsp_data), 0);
        chk("mid rsp_id", 32'(rsp_id), 0);
        chk("mid req_ready", 32'(req_ready), 0);
        chk("mid busy", 32'(busy), 0);
        tick();
        rst  = 1'b0;
        mptr = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("mid no_rsp", 32'(rsp_valid), 0);
            chk("mid idle", 32'(busy), 0);
        end
        set_req(1, 8'hC3, 3);
        req_valid = 4'b0010;
        #1;
        chk("after grant", 32'(req_ready), 32'h2);
        arb_commit(1);
        serve(1, rotl(8'hC3, 3), 3, '0, 1, "after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
